// File: rtl/drac_pkg.sv
// Core-level encodings for the SIMD exe units.
package drac_pkg;
    localparam int VLEN       = 128;
    localparam int BEAT_W_DEF = VLEN / 8;

    typedef enum logic [1:0] {
        VFIRST = 2'b00,
        VCPOP  = 2'b01
    } instr_type_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } vmask_state_t;
endpackage

// File: rtl/riscv_pkg.sv
// Base ISA types shared across the exe stage.
package riscv_pkg;
    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] bus64_t;
endpackage

// File: rtl/vmask_beat_scan.sv
// Combinational scan of one mask beat: active elements, popcount, any-set and
// lowest active index.
module vmask_beat_scan #(
    parameter int BEAT_W = 16,
    parameter int VL_W   = 8,
    parameter int POP_W  = $clog2(BEAT_W + 1),
    parameter int LOW_W  = (BEAT_W > 1) ? $clog2(BEAT_W) : 1
) (
    input  logic [BEAT_W-1:0] vs2,
    input  logic [BEAT_W-1:0] vm,
    input  logic              use_mask,
    input  logic [VL_W-1:0]   vl,
    input  logic [VL_W-1:0]   base,
    output logic [POP_W-1:0]  pop,
    output logic              any,
    output logic [LOW_W-1:0]  low
);
    logic [BEAT_W-1:0] active;

    // One extra bit on the element index so base+j never wraps past vl.
    for (genvar j = 0; j < BEAT_W; j++) begin : g_elem
        assign active[j] = vs2[j] & (vm[j] | ~use_mask) &
                           (({1'b0, base} + (VL_W+1)'(j)) < {1'b0, vl});
    end

    assign any = |active;

    always_comb begin
        pop = '0;
        for (int j = 0; j < BEAT_W; j++)
            pop = pop + POP_W'(active[j]);
    end

    always_comb begin
        low = '0;
        for (int j = BEAT_W - 1; j >= 0; j--)
            if (active[j]) low = LOW_W'(j);
    end
endmodule

// File: rtl/vmask_scalar_reduce.sv
// vfirst.m / vcpop.m reducer over a streamed mask operand.
// Optional: VMASK_FIRST_EARLY_EXIT_EN ends VFIRST at the beat holding the first hit.
module vmask_scalar_reduce
    import drac_pkg::*;
    import riscv_pkg::*;
#(
    parameter int BEAT_W    = BEAT_W_DEF,
    parameter int MAX_BEATS = 8,
    parameter int VL_W      = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  instr_type_t       instr_type_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic              use_mask_i,
    input  logic              beat_valid_i,
    output logic              beat_ready_o,
    input  logic [BEAT_W-1:0] data_vs2_i,
    input  logic [BEAT_W-1:0] data_vm_i,
    input  logic              kill_i,
    output logic              busy_o,
    output logic              result_valid_o,
    output bus64_t            result_o
);
    localparam int CNT_W = $clog2(BEAT_W * MAX_BEATS + 1);
    localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int POP_W = $clog2(BEAT_W + 1);
    localparam int LOW_W = (BEAT_W > 1) ? $clog2(BEAT_W) : 1;

    vmask_state_t      state, state_d;
    instr_type_t       op, op_d;
    logic [VL_W-1:0]   vl_q, vl_d;
    logic              um_q, um_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d, last_idx;
    logic              found, found_d;
    logic [VL_W-1:0]   first, first_d, base;
    bus64_t            result_q, result_d;
    logic              load_res;

    logic [POP_W-1:0]  scan_pop;
    logic              scan_any;
    logic [LOW_W-1:0]  scan_low;

    assign base     = VL_W'(32'(idx) * 32'(BEAT_W));
    assign last_idx = IDX_W'((32'(vl_q) + 32'(BEAT_W - 1)) / 32'(BEAT_W) - 32'd1);

    vmask_beat_scan #(.BEAT_W(BEAT_W), .VL_W(VL_W)) u_scan (
        .vs2      (data_vs2_i),
        .vm       (data_vm_i),
        .use_mask (um_q),
        .vl       (vl_q),
        .base     (base),
        .pop      (scan_pop),
        .any      (scan_any),
        .low      (scan_low)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            op       <= VFIRST;
            vl_q     <= '0;
            um_q     <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            found    <= 1'b0;
            first    <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            op    <= op_d;
            vl_q  <= vl_d;
            um_q  <= um_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            found <= found_d;
            first <= first_d;
            if (load_res) result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state;
        op_d    = op;
        vl_d    = vl_q;
        um_d    = um_q;
        cnt_d   = cnt;
        idx_d   = idx;
        found_d = found;
        first_d = first;
        unique case (state)
            IDLE: if (start_i) begin
                op_d    = instr_type_i;
                vl_d    = vl_i;
                um_d    = use_mask_i;
                cnt_d   = '0;
                idx_d   = '0;
                found_d = 1'b0;
                first_d = '0;
                state_d = (vl_i == '0) ? DONE : ACCUM;
            end
            ACCUM: if (beat_valid_i) begin
                cnt_d = cnt + CNT_W'(scan_pop);
                idx_d = idx + IDX_W'(1);
                if (!found && scan_any) begin
                    found_d = 1'b1;
                    first_d = base + VL_W'(scan_low);
                end
                if (idx == last_idx) state_d = DONE;
`ifdef VMASK_FIRST_EARLY_EXIT_EN
                if (op == VFIRST && !found && scan_any) state_d = DONE;
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    // Result is latched on DONE entry so it is stable for the whole strobe cycle.
    always_comb begin
        load_res = (state_d == DONE) && (state != DONE);
        if (op_d == VFIRST)
            result_d = found_d ? {{(XLEN-VL_W){1'b0}}, first_d} : '1;
        else
            result_d = {{(XLEN-CNT_W){1'b0}}, cnt_d};
    end

    assign busy_o         = (state != IDLE);
    assign beat_ready_o   = (state == ACCUM);
    assign result_valid_o = (state == DONE) && !kill_i;
    assign result_o       = result_q;
endmodule

// File: tb/tb_vmask_scalar_reduce.sv
// Scoreboard bench for vmask_scalar_reduce: directed vectors, queue-based monitor.
module tb_vmask_scalar_reduce;
    import drac_pkg::*;
    import riscv_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    instr_type_t instr_type_i = VCPOP;
    logic [7:0]  vl_i = '0;
    logic        use_mask_i = 1'b0;
    logic        beat_valid_i = 1'b0;
    logic        beat_ready_o;
    logic [15:0] data_vs2_i = '0;
    logic [15:0] data_vm_i = '0;
    logic        kill_i = 1'b0;
    logic        busy_o;
    logic        result_valid_o;
    bus64_t      result_o;

    vmask_scalar_reduce dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .instr_type_i(instr_type_i),
        .vl_i(vl_i), .use_mask_i(use_mask_i), .beat_valid_i(beat_valid_i),
        .beat_ready_o(beat_ready_o), .data_vs2_i(data_vs2_i), .data_vm_i(data_vm_i),
        .kill_i(kill_i), .busy_o(busy_o), .result_valid_o(result_valid_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { bus64_t val; int lat; string name; } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    int n_beats  = 0;

    localparam bus64_t ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    always @(posedge clk_i) cyc <= cyc + 1;
    always @(negedge clk_i) if (beat_valid_i && beat_ready_o) n_beats++;

    task automatic check(input string nm, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: every result strobe must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (result_valid_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %0h, expected no result", result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_value"}, result_o, e.val);
                if (e.lat >= 0) check({e.name, "_latency"}, cyc - start_cyc, e.lat);
            end
        end
    end

    task automatic do_start(input instr_type_t op, input logic [7:0] vl, input logic um);
        @(posedge clk_i); #1;
        start_i = 1'b1; instr_type_i = op; vl_i = vl; use_mask_i = um;
        start_cyc = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    task automatic expect_res(input bus64_t v, input int lat, input string nm);
        exp_t e;
        e.val = v; e.lat = lat; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic send_beat(input logic [15:0] v, input logic [15:0] m, input int stall);
        bit ok;
        beat_valid_i = 1'b0;
        repeat (stall) begin @(posedge clk_i); #1; end
        data_vs2_i = v; data_vm_i = m; beat_valid_i = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk_i);
            if (beat_ready_o) begin ok = 1'b1; break; end
        end
        @(posedge clk_i); #1;
        beat_valid_i = 1'b0;
        if (!ok) check("beat_accept_timeout", 0, 1);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk_i);
        if (sb.size() != 0) begin
            check({nm, "_result_timeout"}, sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    int b0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_ready", beat_ready_o, 0);
        check("rst_valid", result_valid_o, 0);
        check("rst_result", result_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;

        // VCPOP single beat
        b0 = n_beats;
        expect_res(64'd6, 2, "cpop_1beat");
        do_start(VCPOP, 8'd16, 1'b0);
        send_beat(16'h00F3, 16'h0000, 0);
        drain("cpop_1beat");
        check("cpop_1beat_beats", n_beats - b0, 1);

        // Unknown op encoding behaves as VCPOP
        expect_res(64'd6, 2, "op_other");
        do_start(instr_type_t'(2'd3), 8'd16, 1'b0);
        send_beat(16'h00F3, 16'h0000, 0);
        drain("op_other");

        // VCPOP with v0 mask and vl tail inside one beat
        expect_res(64'd8, 2, "cpop_mask_tail");
        do_start(VCPOP, 8'd12, 1'b1);
        send_beat(16'hFFFF, 16'h0F0F, 0);
        drain("cpop_mask_tail");

        // VFIRST across beats, masked
        b0 = n_beats;
`ifdef VMASK_FIRST_EARLY_EXIT_EN
        expect_res(64'd18, 3, "first_mask");
        do_start(VFIRST, 8'd40, 1'b1);
        send_beat(16'h0100, 16'h0000, 0);
        send_beat(16'h0004, 16'hFFFF, 0);
        @(negedge clk_i);
        check("first_mask_ready_after", beat_ready_o, 0);
        drain("first_mask");
        check("first_mask_beats", n_beats - b0, 2);
`else
        expect_res(64'd18, 4, "first_mask");
        do_start(VFIRST, 8'd40, 1'b1);
        send_beat(16'h0100, 16'h0000, 0);
        send_beat(16'h0004, 16'hFFFF, 0);
        send_beat(16'hFFFF, 16'hFFFF, 0);
        drain("first_mask");
        check("first_mask_beats", n_beats - b0, 3);
`endif

        // VFIRST with hits only past vl
        expect_res(ONES, 3, "first_tail");
        do_start(VFIRST, 8'd20, 1'b0);
        send_beat(16'h0000, 16'h0000, 0);
        send_beat(16'hFFF0, 16'h0000, 0);
        drain("first_tail");

        // vl = 0
        b0 = n_beats;
        expect_res(64'd0, 1, "cpop_vl0");
        do_start(VCPOP, 8'd0, 1'b0);
        drain("cpop_vl0");
        expect_res(ONES, 1, "first_vl0");
        do_start(VFIRST, 8'd0, 1'b0);
        drain("first_vl0");
        check("vl0_beats", n_beats - b0, 0);

        // Stalls then kill with the third beat: no result expected
        do_start(VCPOP, 8'd48, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 0);
        send_beat(16'h0001, 16'h0000, 3);
        repeat (3) begin @(posedge clk_i); #1; end
        data_vs2_i = 16'h00FF; beat_valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i); #1;
        beat_valid_i = 1'b0; kill_i = 1'b0;
        @(negedge clk_i);
        check("kill_busy", busy_o, 0);
        check("kill_result_held", result_o, ONES);
        repeat (5) @(negedge clk_i);

        // Restart after kill
        expect_res(64'd25, 4, "cpop_after_kill");
        do_start(VCPOP, 8'd48, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 0);
        send_beat(16'h0001, 16'h0000, 0);
        send_beat(16'h00FF, 16'h0000, 0);
        drain("cpop_after_kill");

        // start_i while busy is ignored
        expect_res(64'd20, -1, "busy_start");
        do_start(VCPOP, 8'd32, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 0);
        start_i = 1'b1; instr_type_i = VFIRST; vl_i = 8'd0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        send_beat(16'h000F, 16'h0000, 0);
        drain("busy_start");

        // Synchronous reset mid-ACCUM
        do_start(VCPOP, 8'd32, 1'b0);
        send_beat(16'hFFFF, 16'h0000, 0);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("midrst_busy", busy_o, 0);
        check("midrst_ready", beat_ready_o, 0);
        check("midrst_valid", result_valid_o, 0);
        check("midrst_result", result_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("final_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/vmask_scalar_reduce.md
Name: vmask_scalar_reduce

Overview:
- Multi-cycle mask-to-scalar reducer for the SIMD exe stage. It executes vfirst.m (index of the first active set element, or -1) and vcpop.m (count of active set elements).
- Counterpart of the mask-generating set-before/including/only-first units: it reads a mask register back into an XLEN scalar instead of writing one.
- Mask operand arrives as a stream of BEAT_W-bit beats, so register groups wider than one beat are supported.

Parameters:
- BEAT_W, 16, mask bits per beat (VLEN/8).
- MAX_BEATS, 8, maximum beats per operation.
- VL_W, 8, width of vl_i; must hold BEAT_W*MAX_BEATS.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  launch operation; sampled only in IDLE.
- instr_type_i  in  instr_type_t  VFIRST or VCPOP; any other value is treated as VCPOP.
- vl_i  in  VL_W  active vector length, in elements.
- use_mask_i  in  1  apply v0 mask.
- beat_valid_i  in  1  beat present.
- beat_ready_o  out  1  beat accepted when valid&ready.
- data_vs2_i  in  BEAT_W  source mask beat.
- data_vm_i  in  BEAT_W  v0 mask beat.
- kill_i  in  1  pipeline flush.
- busy_o  out  1  FSM not in IDLE.
- result_valid_o  out  1  one-cycle result strobe.
- result_o  out  64  scalar result.

Behaviour:
- Reset values: FSM=IDLE; busy_o=0, beat_ready_o=0, result_valid_o=0, result_o=0; all internal accumulators 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start_i&~kill_i captures op, vl, use_mask; clears cnt, beat index, found flag, first index.
  - If vl_i==0, go to DONE; otherwise go to ACCUM.
  - beat_ready_o=0 in IDLE.
- ACCUM:
  - beat_ready_o=1.
  - Beat b covers elements e=b*BEAT_W+j.
  - active[j] = vs2[j] & (vm[j] | ~use_mask) & (e < vl).
  - cnt += popcount(active).
  - If ~found and |active: found=1, first=e of the lowest set j.
  - The beat with b == ceil(vl/BEAT_W)-1 is the last beat: accept it, then go to DONE.
- DONE:
  - result_valid_o=1 for exactly one cycle, then go to IDLE. No back-pressure.
  - VCPOP: result_o = zero-extended cnt.
  - VFIRST: result_o = zero-extended first if found, else 64'hFFFF_FFFF_FFFF_FFFF.
  - result_o holds its value until the next DONE.
- Latency: start to result_valid = nbeats+1 cycles with no stalls; vl=0 gives 1 cycle.
- Stalls: cycles with beat_valid_i=0 in ACCUM leave all state unchanged.
- kill_i, any state: next state is IDLE; no result_valid_o; result_o is held. kill_i wins over a simultaneous start_i or final beat.
- start_i outside IDLE is ignored. The issue logic must gate start_i on ~busy_o.
- Bits of the last beat at or above vl are ignored regardless of value (tail-agnostic input).
- cnt width: clog2(BEAT_W*MAX_BEATS+1). No overflow is possible.

Optional Feature:
- Macro: VMASK_FIRST_EARLY_EXIT_EN.
- Defined: for VFIRST only, the beat where found first becomes 1 ends ACCUM; the FSM goes to DONE next cycle.
  - The producer must stop issuing beats once busy_o falls or result_valid_o rises.
  - Leftover beats see beat_ready_o=0.
- Undefined: all ceil(vl/BEAT_W) beats are always consumed.
- VCPOP timing is identical in both builds.

Decomposition:
- drac_pkg: instr_type_t (VFIRST, VCPOP encodings), and a constant equal to VLEN/8 used as the BEAT_W default.
- riscv_pkg: XLEN-wide bus64_t.
- One sub-module, vmask_beat_scan: combinational. Takes one beat plus vl/base and produces the active vector, popcount, any-set flag and lowest-set index.
- FSM and accumulators stay in the top module.

Test Plan:
- VCPOP, vl=16, use_mask=0, vs2=16'h00F3 in one beat -> result_valid 2 cycles after start; result_o=6.
- VFIRST, vl=40, use_mask=1:
  - beat0 vs2=16'h0100, vm=16'h0000; beat1 vs2=16'h0004, vm=16'hFFFF; beat2 don't-care -> result_o=18.
  - Without macro, 3 beats are consumed; with macro, 2 beats, and beat_ready_o=0 afterwards.
- VFIRST, vl=20, vs2 beat0=0, beat1=16'hFFF0 -> elements 20..31 are masked by vl; result_o=64'hFFFF_FFFF_FFFF_FFFF.
- vl=0, VCPOP and VFIRST -> no beats accepted; result_valid 1 cycle after start; results 0 and all-ones respectively.
- VCPOP, vl=48, beat_valid_i deasserted 3 cycles between beats; kill_i asserted together with the third beat -> no result_valid_o, busy_o=0 next cycle. A new start then gives the correct count.
- rst_i asserted mid-ACCUM, and start_i pulsed while busy -> FSM returns to IDLE and outputs go to 0 (reset); the busy-time start is ignored (no second result).
